// File: rtl/mc_alu_pkg.sv
// mc_alu_pkg: shared definitions for the multi-cycle ALU.
//   DEFAULT_WIDTH  default operand/result width
//   OP_*           3-bit opcode encodings
//   state_t        controller state type
package mc_alu_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_XNOR = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mc_alu_muldiv.sv
// mc_alu_muldiv: iterative unsigned multiplier / restoring divider, one bit
// per cycle on a single shared shift datapath.
//   clk, rst   clock, synchronous active-high reset
//   start      load operands and perform the first iteration
//   op         OP_MUL or OP_DIV (sampled at start only)
//   a, b       operands (MUL: a*b, DIV: a/b)
//   done       one-cycle pulse once lo/hi hold the final value
//   lo, hi     MUL: product low/high, DIV: quotient/remainder
module mc_alu_muldiv
   import mc_alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CW = $clog2(WIDTH);
   // The start edge already performs one iteration, so WIDTH-1 remain.
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 2);

   logic [WIDTH-1:0] m_q, hi_q, lo_q;
   logic             is_div_q, busy_q, done_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH-1:0] m_src, hi_src, lo_src, addend, hi_nxt, lo_nxt;
   logic             div_src;
   logic [WIDTH:0]   sum, trial;

   // On start the step operates on the fresh operands instead of the registers.
   always_comb begin
      if (start) begin
         div_src = (op == OP_DIV);
         m_src   = div_src ? b : a;
         lo_src  = div_src ? a : b;
         hi_src  = '0;
      end else begin
         div_src = is_div_q;
         m_src   = m_q;
         lo_src  = lo_q;
         hi_src  = hi_q;
      end
      addend = lo_src[0] ? m_src : '0;
      sum    = {1'b0, hi_src} + {1'b0, addend};
      // Remainder < divisor, so the shifted partial remainder fits WIDTH+1
      // bits; bit WIDTH of the difference is set exactly when it underflows.
      trial  = {hi_src, lo_src[WIDTH-1]} - {1'b0, m_src};
      if (div_src) begin
         if (!trial[WIDTH]) begin
            hi_nxt = trial[WIDTH-1:0];
            lo_nxt = {lo_src[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = {hi_src[WIDTH-2:0], lo_src[WIDTH-1]};
            lo_nxt = {lo_src[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_nxt = sum[WIDTH:1];
         lo_nxt = {sum[0], lo_src[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            m_q      <= m_src;
            hi_q     <= hi_nxt;
            lo_q     <= lo_nxt;
            is_div_q <= div_src;
            cnt_q    <= CNT_LOAD;
            busy_q   <= 1'b1;
         end else if (busy_q) begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done = done_q;
   assign lo   = lo_q;
   assign hi   = hi_q;

endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with valid/ready handshakes on both sides.
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   a, b, op              operands and opcode, captured at accept
//   out_valid / out_ready result handshake, outputs held until taken
//   result, result_hi     primary result / product-high or remainder
//   carry, sign, parity, overflow, zero, div_by_zero   registered flags
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request, in_ready=1
// BUSY  | MUL or DIV (b!=0) iterating in mc_alu_muldiv
// DONE  | out_valid=1, outputs held until out_ready
module mc_alu
   import mc_alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry,
   output logic             sign,
   output logic             parity,
   output logic             overflow,
   output logic             zero,
   output logic             div_by_zero
);

   state_t           state_q, state_d;
   logic [2:0]       op_q;
   logic             accept, md_start, md_done;
   logic [WIDTH-1:0] md_lo, md_hi;
   logic             load_sc, load_md;

   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] sc_res, sc_hi;
   logic             sc_c, sc_v, sc_dz;

   logic [WIDTH-1:0] nxt_res, nxt_hi;
   logic             nxt_c, nxt_v, nxt_dz;

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign accept    = in_valid & in_ready;
   // Divide by zero bypasses the iterative unit and completes in one cycle.
   assign md_start  = accept & ((op == OP_MUL) | ((op == OP_DIV) & (|b)));

   mc_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk   (clk),
      .rst   (rst),
      .start (md_start),
      .op    (op),
      .a     (a),
      .b     (b),
      .done  (md_done),
      .lo    (md_lo),
      .hi    (md_hi)
   );

   // Single-cycle results, computed straight from the request inputs.
   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} - {1'b0, b};
      sc_res = '0;
      sc_hi  = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_dz  = 1'b0;
      case (op)
         OP_ADD: begin
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = diff[WIDTH-1:0];
            sc_c   = diff[WIDTH];
            sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_DIV: begin
            sc_res = '1;
            sc_hi  = a;
            sc_dz  = 1'b1;
         end
         OP_AND:  sc_res = a & b;
         OP_OR:   sc_res = a | b;
         OP_XOR:  sc_res = a ^ b;
         OP_XNOR: sc_res = ~(a ^ b);
         default: sc_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      load_sc = 1'b0;
      load_md = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (md_start) begin
                  state_d = S_BUSY;
               end else begin
                  state_d = S_DONE;
                  load_sc = 1'b1;
               end
            end
         end
         S_BUSY: begin
            if (md_done) begin
               state_d = S_DONE;
               load_md = 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst)         op_q <= OP_ADD;
      else if (accept) op_q <= op;
   end

   always_comb begin
      nxt_res = load_md ? md_lo : sc_res;
      nxt_hi  = load_md ? md_hi : sc_hi;
      nxt_c   = load_md ? ((op_q == OP_MUL) && (|md_hi)) : sc_c;
      nxt_v   = load_md ? ((op_q == OP_MUL) && (|md_hi)) : sc_v;
      nxt_dz  = load_md ? 1'b0 : sc_dz;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result      <= '0;
         result_hi   <= '0;
         carry       <= 1'b0;
         sign        <= 1'b0;
         parity      <= 1'b0;
         overflow    <= 1'b0;
         zero        <= 1'b0;
         div_by_zero <= 1'b0;
      end else if (load_sc || load_md) begin
         result      <= nxt_res;
         result_hi   <= nxt_hi;
         carry       <= nxt_c;
         sign        <= nxt_res[WIDTH-1];
         parity      <= ~^nxt_res;
         overflow    <= nxt_v;
         zero        <= ~|nxt_res;
         div_by_zero <= nxt_dz;
      end
   end

endmodule

// File: tb/tb_mc_alu.sv
module tb_mc_alu;

   localparam int W   = 8;
   localparam int BIG = 32'h7fff_ffff;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   op = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] result, result_hi;
   logic         carry, sign, parity, overflow, zero, div_by_zero;

   mc_alu #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .op          (op),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .result_hi   (result_hi),
      .carry       (carry),
      .sign        (sign),
      .parity      (parity),
      .overflow    (overflow),
      .zero        (zero),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         c, s, p, v, z, dz;
      int           lat;
   } exp_t;

   // Model state, written only by the driver: accept/valid/end cycle numbers.
   exp_t exp_cur;
   int   cyc = 0;
   int   acc_cyc = BIG;
   int   val_cyc = BIG;
   int   done_cyc = BIG;
   bit   chk_zero = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   function automatic exp_t zero_exp();
      exp_t e;
      e.res = '0; e.hi = '0; e.c = 0; e.s = 0; e.p = 0; e.v = 0; e.z = 0; e.dz = 0; e.lat = 0;
      return e;
   endfunction

   function automatic exp_t model(input int unsigned ia, input int unsigned ib, input int iop);
      exp_t        e;
      int unsigned r, h, p;
      e   = zero_exp();
      e.lat = 1;
      h   = 0;
      r   = 0;
      case (iop)
         0: begin
            r   = ia + ib;
            e.c = (r > 255);
            r   = r % 256;
            e.v = ((ia >= 128) == (ib >= 128)) && ((r >= 128) != (ia >= 128));
         end
         1: begin
            r   = (ia + 256 - ib) % 256;
            e.c = (ia < ib);
            e.v = ((ia >= 128) != (ib >= 128)) && ((r >= 128) != (ia >= 128));
         end
         2: begin
            p = ia * ib;
            r = p % 256;
            h = p / 256;
            e.c = (h != 0);
            e.v = e.c;
            e.lat = W + 1;
         end
         3: begin
            if (ib == 0) begin
               r = 255; h = ia; e.dz = 1;
            end else begin
               r = ia / ib; h = ia % ib; e.lat = W + 1;
            end
         end
         4: r = ia & ib;
         5: r = ia | ib;
         6: r = ia ^ ib;
         default: r = 255 - (ia ^ ib);
      endcase
      e.res = 8'(r);
      e.hi  = 8'(h);
      e.s   = (r >= 128);
      e.z   = (r == 0);
      e.p   = ($countones(r) % 2) == 0;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Compare process: model pins first, then every cycle against the model.
   initial begin : compare
      exp_t m, r;
      bit   act, ev;
      m = model(200, 100, 0);
      chk("pin_add_res", 32'(m.res), 32'h2C); chk("pin_add_c", 32'(m.c), 32'd1);
      chk("pin_add_v", 32'(m.v), 32'd0);      chk("pin_add_lat", 32'(m.lat), 32'd1);
      m = model(100, 50, 0);
      chk("pin_add2_res", 32'(m.res), 32'h96); chk("pin_add2_s", 32'(m.s), 32'd1);
      chk("pin_add2_v", 32'(m.v), 32'd1);      chk("pin_add2_c", 32'(m.c), 32'd0);
      m = model(5, 7, 1);
      chk("pin_sub_res", 32'(m.res), 32'hFE); chk("pin_sub_c", 32'(m.c), 32'd1);
      chk("pin_sub_v", 32'(m.v), 32'd0);      chk("pin_sub_z", 32'(m.z), 32'd0);
      m = model(200, 3, 2);
      chk("pin_mul_res", 32'(m.res), 32'h58); chk("pin_mul_hi", 32'(m.hi), 32'h02);
      chk("pin_mul_v", 32'(m.v), 32'd1);      chk("pin_mul_lat", 32'(m.lat), 32'd9);
      m = model(100, 7, 3);
      chk("pin_div_res", 32'(m.res), 32'd14); chk("pin_div_hi", 32'(m.hi), 32'd2);
      m = model(9, 0, 3);
      chk("pin_dz_res", 32'(m.res), 32'hFF);  chk("pin_dz_hi", 32'(m.hi), 32'd9);
      chk("pin_dz_flag", 32'(m.dz), 32'd1);   chk("pin_dz_lat", 32'(m.lat), 32'd1);
      m = model(32'h5A, 32'h5A, 6);
      chk("pin_xor_z", 32'(m.z), 32'd1);      chk("pin_xor_p", 32'(m.p), 32'd1);
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         act = (cyc >= acc_cyc) && (cyc < done_cyc);
         ev  = act && (cyc >= val_cyc);
         chk("in_ready", 32'(in_ready), 32'(!act));
         chk("out_valid", 32'(out_valid), 32'(ev));
         if (ev || chk_zero) begin
            r = ev ? exp_cur : zero_exp();
            chk("result", 32'(result), 32'(r.res));
            chk("result_hi", 32'(result_hi), 32'(r.hi));
            chk("carry", 32'(carry), 32'(r.c));
            chk("sign", 32'(sign), 32'(r.s));
            chk("parity", 32'(parity), 32'(r.p));
            chk("overflow", 32'(overflow), 32'(r.v));
            chk("zero", 32'(zero), 32'(r.z));
            chk("div_by_zero", 32'(div_by_zero), 32'(r.dz));
         end
      end
   end

   // Called at a negedge while the DUT is idle; the next posedge accepts.
   task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top);
      a = ta; b = tb; op = top;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      exp_cur   = model(32'(ta), 32'(tb), 32'(top));
      chk_zero  = 1'b0;
      acc_cyc   = cyc + 1;
      val_cyc   = acc_cyc + exp_cur.lat - 1;
      done_cyc  = BIG;
      @(negedge clk);
   endtask

   task automatic noise_inputs(input bit noise, input bit allow_ready);
      in_valid  = noise ? 1'($urandom) : 1'b0;
      out_ready = (noise && allow_ready) ? 1'($urandom) : 1'b0;
      if (noise) begin
         a  = 8'($urandom);
         b  = 8'($urandom);
         op = 3'($urandom);
      end
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top,
                         input int hold, input bit noise);
      launch(ta, tb, top);
      while (cyc < val_cyc + hold) begin
         noise_inputs(noise, cyc < val_cyc);
         @(negedge clk);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      done_cyc  = cyc + 1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // Reset hits the posedge k cycles after the accept edge.
   task automatic abort_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top,
                           input int k);
      launch(ta, tb, top);
      while (cyc < acc_cyc + k - 1) begin
         noise_inputs(1'b1, 1'b0);
         @(negedge clk);
      end
      rst      = 1'b1;
      in_valid = 1'b1;
      chk_zero = 1'b1;
      done_cyc = cyc + 1;
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin : drive
      logic [W-1:0] ra, rb;
      logic [2:0]   rop;
      exp_cur  = zero_exp();
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);

      run_op(8'd200, 8'd100, 3'b000, 0, 1'b0);
      run_op(8'd100, 8'd50,  3'b000, 1, 1'b1);
      run_op(8'd5,   8'd7,   3'b001, 0, 1'b0);
      run_op(8'd200, 8'd3,   3'b010, 0, 1'b0);
      run_op(8'd100, 8'd7,   3'b011, 2, 1'b1);
      run_op(8'd9,   8'd0,   3'b011, 0, 1'b0);
      run_op(8'h5A,  8'h5A,  3'b110, 3, 1'b1);
      run_op(8'hF0,  8'h0F,  3'b111, 0, 1'b0);
      abort_op(8'd200, 8'd3, 3'b010, 4);
      run_op(8'd255, 8'd255, 3'b010, 1, 1'b1);
      run_op(8'd255, 8'd1,   3'b011, 0, 1'b0);
      run_op(8'd127, 8'd1,   3'b000, 0, 1'b0);
      run_op(8'd128, 8'd1,   3'b001, 0, 1'b0);

      for (int i = 0; i < 150; i++) begin
         ra  = 8'($urandom);
         rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         rop = 3'($urandom);
         run_op(ra, rb, rop, int'($urandom_range(0, 3)), 1'($urandom));
      end

      abort_op(8'd3, 8'd4, 3'b000, 2);
      abort_op(8'd77, 8'd5, 3'b011, 9);
      run_op(8'd77, 8'd5, 3'b011, 0, 1'b0);
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
